// File: rtl/ccu_cmd_pkg.sv
// Shared definitions for the CCU command transmitter.
// Holds the opcode values, the transmitter state type, the argument field
// selector type and the per-opcode helpers (argument count and argument order).
package ccu_cmd_pkg;

  localparam logic [7:0] OP_NOP   = 8'd0;
  localparam logic [7:0] OP_CLEAR = 8'd67;
  localparam logic [7:0] OP_LINE  = 8'd76;
  localparam logic [7:0] OP_PIXEL = 8'd80;
  localparam logic [7:0] OP_RECT  = 8'd82;

  typedef enum logic [1:0] {
    StIdle,
    StSendOp,
    StSendArg,
    StGap
  } state_e;

  typedef enum logic [2:0] {
    SelXs,
    SelYs,
    SelXe,
    SelYe,
    SelColor,
    SelNone
  } arg_sel_e;

  // Number of argument bytes following the opcode; 0 marks an unsupported opcode.
  function automatic logic [2:0] op_nargs(input logic [7:0] op);
    logic [2:0] n;
    case (op)
      OP_LINE, OP_RECT: n = 3'd5;
      OP_PIXEL:         n = 3'd3;
      OP_CLEAR:         n = 3'd1;
      default:          n = 3'd0;
    endcase
    return n;
  endfunction

  // Which request field goes out as argument number idx of opcode op.
  function automatic arg_sel_e arg_sel(input logic [7:0] op, input logic [2:0] idx);
    arg_sel_e sel;
    sel = SelNone;
    case (op)
      OP_LINE, OP_RECT: begin
        case (idx)
          3'd0:    sel = SelXs;
          3'd1:    sel = SelYs;
          3'd2:    sel = SelXe;
          3'd3:    sel = SelYe;
          3'd4:    sel = SelColor;
          default: sel = SelNone;
        endcase
      end
      OP_PIXEL: begin
        case (idx)
          3'd0:    sel = SelXs;
          3'd1:    sel = SelYs;
          3'd2:    sel = SelColor;
          default: sel = SelNone;
        endcase
      end
      OP_CLEAR: sel = (idx == 3'd0) ? SelColor : SelNone;
      default:  sel = SelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ccu_arg_mux.sv
// Combinational argument byte selector.
// Ports:
//   op_i               latched opcode
//   idx_i              argument index within the frame
//   xs_i..color_i      latched request fields
//   arg_o              selected argument byte (0 when the index is out of range)
module ccu_arg_mux
  import ccu_cmd_pkg::*;
(
  input  logic [7:0] op_i,
  input  logic [2:0] idx_i,
  input  logic [7:0] xs_i,
  input  logic [7:0] ys_i,
  input  logic [7:0] xe_i,
  input  logic [7:0] ye_i,
  input  logic [7:0] color_i,
  output logic [7:0] arg_o
);

  arg_sel_e sel;

  assign sel = arg_sel(op_i, idx_i);

  always_comb begin
    arg_o = OP_NOP;
    case (sel)
      SelXs:    arg_o = xs_i;
      SelYs:    arg_o = ys_i;
      SelXe:    arg_o = xe_i;
      SelYe:    arg_o = ye_i;
      SelColor: arg_o = color_i;
      default:  arg_o = OP_NOP;
    endcase
  end

endmodule

// File: rtl/ccu_cmd_tx.sv
// Host-side CCU command transmitter.
// Accepts one drawing request per valid/ready handshake, then serialises the
// opcode and its argument bytes onto the registered cmd bus, one per clock,
// followed by GAP_CYCLES NOP cycles.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_op..req_color        request fields (sampled only at acceptance)
//   cmd                      registered byte to the CCU, 0 = NOP
//   busy                     high from acceptance until the last gap cycle
//   err                      one-cycle pulse after an unsupported opcode is accepted
module ccu_cmd_tx
  import ccu_cmd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 32,
  parameter int unsigned OP_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [OP_W-1:0] req_xs,
  input  logic [OP_W-1:0] req_ys,
  input  logic [OP_W-1:0] req_xe,
  input  logic [OP_W-1:0] req_ye,
  input  logic [OP_W-1:0] req_color,
  output logic [OP_W-1:0] cmd,
  output logic            busy,
  output logic            err
);

  localparam int unsigned CntW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] GapInit = CntW'(GAP_CYCLES);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      op_q, op_d, xs_q, xs_d, ys_q, ys_d;
  logic [7:0]      xe_q, xe_d, ye_q, ye_d, color_q, color_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            err_q, err_d;
  logic [7:0]      arg_byte;

  assign req_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign cmd       = cmd_q;
  assign err       = err_q;

  // Indexed by the next index so cmd_q carries the byte for the state being entered.
  ccu_arg_mux u_arg_mux (
    .op_i    (op_q),
    .idx_i   (idx_d),
    .xs_i    (xs_q),
    .ys_i    (ys_q),
    .xe_i    (xe_q),
    .ye_i    (ye_q),
    .color_i (color_q),
    .arg_o   (arg_byte)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    color_d = color_q;
    err_d   = 1'b0;
    cmd_d   = OP_NOP;

    case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          xs_d    = req_xs;
          ys_d    = req_ys;
          xe_d    = req_xe;
          ye_d    = req_ye;
          color_d = req_color;
          if (op_nargs(req_op) != 3'd0) begin
            state_d = StSendOp;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSendOp: begin
        state_d = StSendArg;
        idx_d   = 3'd0;
      end
      StSendArg: begin
        if (idx_q == op_nargs(op_q) - 3'd1) begin
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            cnt_d   = GapInit;
          end else begin
            state_d = StIdle;
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StGap: begin
        // Counts GAP_CYCLES down to 1; leaving on 1 gives exactly GAP_CYCLES NOPs.
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    case (state_d)
      StSendOp:  cmd_d = op_d;
      StSendArg: cmd_d = arg_byte;
      default:   cmd_d = OP_NOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      color_q <= '0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      color_q <= color_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/ccu_cmd_tx.md
Name: ccu_cmd_tx

Overview:
- Host-side transmitter for the CCU command byte stream.
- Accepts one drawing request per handshake (opcode, Xs, Ys, Xe, Ye, color).
- Serialises the request onto the 8-bit cmd bus that the CCU samples every clock: opcode byte first, then that opcode's argument bytes, one per clock.
- After each frame it holds the bus at 0 (NOP) for a fixed guard gap so the CCU can finish generating its Kbus control words.

Parameters:
- GAP_CYCLES, 32, number of NOP (0) cycles driven after the last argument byte before the next request is accepted; legal range 0..255.
- OP_W, 8, width of the opcode and each argument byte; fixed at 8 (CCU cmd width).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  transmitter can accept a request this cycle.
- req_op  input  8  opcode.
- req_xs  input  8  start X.
- req_ys  input  8  start Y.
- req_xe  input  8  end X.
- req_ye  input  8  end Y.
- req_color  input  8  colour index.
- cmd  output  8  registered byte to the CCU cmd input; 0 = NOP.
- busy  output  1  high from acceptance until the last gap cycle completes.
- err  output  1  one-cycle pulse when an unsupported opcode is accepted.

Behaviour:
- Reset (async, immediate): cmd=0, req_ready=0 while rst high, busy=0, err=0, state=IDLE, all counters and holding registers cleared. req_ready rises in the first cycle after rst deasserts.
- Supported opcodes and argument order, from the shared package:
  - OP_LINE=76: 5 args, in order Xs, Ys, Xe, Ye, color.
  - OP_RECT=82: 5 args, same order.
  - OP_PIXEL=80: 3 args, in order Xs, Ys, color.
  - OP_CLEAR=67: 1 arg, color.
  - Any other value, including 0, is unsupported.
- States: IDLE, SEND_OP, SEND_ARG, GAP.
- IDLE:
  - req_ready=1, cmd=0.
  - On req_valid && req_ready, latch all six request fields.
  - Supported opcode: go to SEND_OP.
  - Unsupported opcode: err=1 for the next cycle, nothing transmitted, stay IDLE.
- SEND_OP:
  - cmd=opcode, driven in the cycle after acceptance (latency 1).
  - Next state SEND_ARG, argument index 0.
- SEND_ARG:
  - cmd = argument[index] per the opcode's order, one byte per cycle.
  - After the last argument: go to GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP:
  - cmd=0 for exactly GAP_CYCLES cycles, then IDLE.
- req_ready=1 only in IDLE and not in reset. busy = (state != IDLE).
- Frame timing: length = 1 + nargs bytes. Minimum spacing between opcode bytes of back-to-back requests = 1 + nargs + GAP_CYCLES + 1 cycles. With GAP_CYCLES=0 there is still exactly one 0 byte (the IDLE cycle) between frames.
- Request inputs are ignored when req_ready=0. The latched copy is used, so changes to inputs mid-frame have no effect.
- rst asserted mid-frame: cmd drops to 0 asynchronously and the frame is abandoned. No partial resume.
- Gap counter width is $clog2(GAP_CYCLES+1), minimum 1 bit. The count runs down from GAP_CYCLES to 1 with no wrap.
- err never coincides with busy.

Decomposition:
- Package ccu_cmd_pkg holds:
  - OP_LINE, OP_RECT, OP_PIXEL, OP_CLEAR, OP_NOP=0.
  - The state enum.
  - Function op_nargs(op), returning 0..5; 0 means unsupported.
  - Function arg_sel(op, idx), returning a field selector.
- One sub-module, ccu_arg_mux: combinational selection of the latched field from (op, idx). All sequencing stays in ccu_cmd_tx.

Test Plan:
- Line, GAP_CYCLES=32: req op=76, xs=0, ys=0, xe=50, ye=30, color=10 → cmd = 76, 0, 0, 50, 30, 10 on the 6 cycles after acceptance, then 32 cycles of 0. req_ready low for 38 cycles, busy high for the same 38.
- Pixel then clear, back to back with req_valid held: op=80 (xs=5, ys=7, color=3), then op=67 (color=9) → cmd = 80, 5, 7, 3, 32×0, 0 (IDLE), 67, 9, 32×0.
- Unsupported: op=0 and op=99 → err pulses one cycle each, cmd stays 0, busy stays 0, req_ready high again next cycle.
- Reset mid-frame: assert rst during the Xe byte of a line → cmd=0 in the same cycle without waiting for clk. After release: IDLE, req_ready=1, next request transmitted intact.
- GAP_CYCLES=0 build: two rect requests → cmd = 82, a, b, c, d, e, 0, 82, … (exactly one 0 between frames).
- Input stability: change req_xe while in SEND_ARG → transmitted byte equals the value latched at acceptance.
